// File: rtl/ped_pkg.sv
// Shared types and light-code constants for the pedestrian signal controller.
package ped_pkg;

  typedef enum logic [1:0] {
    PED_DONT_WALK = 2'd0,
    PED_WALK      = 2'd1,
    PED_FLASH     = 2'd2
  } ped_state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == LIGHT_RED) || (code == LIGHT_YEL) || (code == LIGHT_GRN);
  endfunction

endpackage

// File: rtl/ped_phase_fsm.sv
// One crosswalk: button synchronizer, debounce, request latch and WALK/FLASH sequencer.
module ped_phase_fsm
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned WALK_CYC  = 4,
  parameter int unsigned FLASH_CYC = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             green,
  input  logic             fault,
  output logic             walk,
  output logic             dw,
  output logic [CNT_W-1:0] cd,
  output logic             req,
  output logic             abort
);

  localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYC - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] db_cnt;
  logic             accept;

  ped_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phase, phase_nxt;
  logic             req_nxt, abort_nxt, grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (!sync2)
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + 1'b1;
    end
  end

  // Saturation at DB_MAX means a held button yields a single accept.
  assign accept = sync2 && (db_cnt == DB_LAST) && !fault;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    abort_nxt = 1'b0;
    grant     = 1'b0;
    case (state)
      PED_DONT_WALK: begin
        if (req && green && !fault) begin
          grant     = 1'b1;
          state_nxt = PED_WALK;
          cnt_nxt   = WALK_LOAD;
        end
      end
      PED_WALK: begin
        if (!green || fault) begin
          state_nxt = PED_DONT_WALK;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = PED_FLASH;
          cnt_nxt   = FLASH_LOAD;
          phase_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      PED_FLASH: begin
        if (!green || fault) begin
          state_nxt = PED_DONT_WALK;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = PED_DONT_WALK;
        end else begin
          cnt_nxt   = cnt - 1'b1;
          phase_nxt = !phase;
        end
      end
      default: begin
        state_nxt = PED_DONT_WALK;
        cnt_nxt   = '0;
      end
    endcase

    // A press accepted on the grant edge keeps the request for the next green.
    req_nxt = req;
    if (fault)
      req_nxt = 1'b0;
    else if (accept)
      req_nxt = 1'b1;
    else if (grant)
      req_nxt = 1'b0;
  end

  // Lamp outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= PED_DONT_WALK;
      cnt   <= '0;
      phase <= 1'b0;
      req   <= 1'b0;
      abort <= 1'b0;
      walk  <= 1'b0;
      dw    <= 1'b1;
      cd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
      req   <= req_nxt;
      abort <= abort_nxt;
      walk  <= (state_nxt == PED_WALK);
      dw    <= (state_nxt == PED_DONT_WALK) || ((state_nxt == PED_FLASH) && phase_nxt);
      cd    <= (state_nxt == PED_FLASH) ? cnt_nxt + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/ped_signal_controller.sv
// Pedestrian heads for NS/EW crosswalks with light-legality checking and sticky fault.
module ped_signal_controller
  import ped_pkg::*;
#(
  parameter int unsigned DEBOUNCE  = 4,
  parameter int unsigned WALK_CYC  = 4,
  parameter int unsigned FLASH_CYC = 3,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ns_light,
  input  logic [2:0]       ew_light,
  input  logic             btn_ns,
  input  logic             btn_ew,
  output logic             walk_ns,
  output logic             dw_ns,
  output logic [CNT_W-1:0] cd_ns,
  output logic             req_ns,
  output logic             abort_ns,
  output logic             walk_ew,
  output logic             dw_ew,
  output logic [CNT_W-1:0] cd_ew,
  output logic             req_ew,
  output logic             abort_ew,
  output logic             fault
);

  logic illegal;

  // Conflict: at least one direction must be showing red.
  assign illegal = !is_onehot3(ns_light) || !is_onehot3(ew_light) ||
                   ((ns_light != LIGHT_RED) && (ew_light != LIGHT_RED));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fault <= 1'b0;
    else if (illegal)
      fault <= 1'b1;
  end

  ped_phase_fsm #(
    .DEBOUNCE (DEBOUNCE),
    .WALK_CYC (WALK_CYC),
    .FLASH_CYC(FLASH_CYC),
    .CNT_W    (CNT_W)
  ) u_ns (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_ns),
    .green(ns_light == LIGHT_GRN),
    .fault(fault),
    .walk (walk_ns),
    .dw   (dw_ns),
    .cd   (cd_ns),
    .req  (req_ns),
    .abort(abort_ns)
  );

  ped_phase_fsm #(
    .DEBOUNCE (DEBOUNCE),
    .WALK_CYC (WALK_CYC),
    .FLASH_CYC(FLASH_CYC),
    .CNT_W    (CNT_W)
  ) u_ew (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_ew),
    .green(ew_light == LIGHT_GRN),
    .fault(fault),
    .walk (walk_ew),
    .dw   (dw_ew),
    .cd   (cd_ew),
    .req  (req_ew),
    .abort(abort_ew)
  );

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed bench for ped_signal_controller with hand-computed expectations.
module tb_ped_signal_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] ns_light, ew_light;
  logic       btn_ns, btn_ew;
  logic       walk_ns, dw_ns, req_ns, abort_ns;
  logic       walk_ew, dw_ew, req_ew, abort_ew;
  logic [3:0] cd_ns, cd_ew;
  logic       fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ped_signal_controller #(
    .DEBOUNCE (4),
    .WALK_CYC (4),
    .FLASH_CYC(3),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .btn_ns  (btn_ns),
    .btn_ew  (btn_ew),
    .walk_ns (walk_ns),
    .dw_ns   (dw_ns),
    .cd_ns   (cd_ns),
    .req_ns  (req_ns),
    .abort_ns(abort_ns),
    .walk_ew (walk_ew),
    .dw_ew   (dw_ew),
    .cd_ew   (cd_ew),
    .req_ew  (req_ew),
    .abort_ew(abort_ew),
    .fault   (fault)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; ns_light = 3'b001; ew_light = 3'b100; btn_ns = 1'b0; btn_ew = 1'b0;
    tick(2);
    chk("rst_walk_ns", walk_ns, 0);  chk("rst_dw_ns", dw_ns, 1);
    chk("rst_cd_ns", cd_ns, 0);      chk("rst_req_ns", req_ns, 0);
    chk("rst_abort_ns", abort_ns, 0); chk("rst_walk_ew", walk_ew, 0);
    chk("rst_dw_ew", dw_ew, 1);      chk("rst_fault", fault, 0);
    reset = 1'b0;

    // Idle green with no request
    tick(5);
    chk("idle_walk_ns", walk_ns, 0); chk("idle_dw_ns", dw_ns, 1);
    chk("idle_req_ns", req_ns, 0);   chk("idle_fault", fault, 0);

    // NS press on red: request on 6th edge, then full walk/flash
    ns_light = 3'b100; ew_light = 3'b001; btn_ns = 1'b1;
    tick(5); chk("db_early_req_ns", req_ns, 0);
    tick(1); chk("db_accept_req_ns", req_ns, 1);
    tick(2); btn_ns = 1'b0; chk("wait_walk_ns", walk_ns, 0);
    ns_light = 3'b001; ew_light = 3'b100;
    tick(1);
    chk("grant_walk_ns", walk_ns, 1); chk("grant_req_ns", req_ns, 0); chk("grant_dw_ns", dw_ns, 0);
    tick(3); chk("walk_last_ns", walk_ns, 1);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("flash_cd_ns", cd_ns, 8'(3 - i));
      chk("flash_dw_ns", dw_ns, (i == 1) ? 8'd0 : 8'd1);
      chk("flash_walk_ns", walk_ns, 0);
    end
    tick(1);
    chk("end_walk_ns", walk_ns, 0); chk("end_dw_ns", dw_ns, 1);
    chk("end_cd_ns", cd_ns, 0);     chk("end_abort_ns", abort_ns, 0);

    // Abort NS walk when light goes yellow
    ns_light = 3'b100; ew_light = 3'b001; btn_ns = 1'b1;
    tick(6); btn_ns = 1'b0; chk("abort_setup_req_ns", req_ns, 1);
    ns_light = 3'b001; ew_light = 3'b100;
    tick(2); chk("abort_pre_walk_ns", walk_ns, 1);
    ns_light = 3'b010;
    tick(1);
    chk("abort_walk_ns", walk_ns, 0); chk("abort_dw_ns", dw_ns, 1);
    chk("abort_pulse_ns", abort_ns, 1); chk("abort_cd_ns", cd_ns, 0);
    chk("abort_fault", fault, 0);
    tick(1); chk("abort_one_cycle_ns", abort_ns, 0);

    // EW held 20 cycles yields one request
    ns_light = 3'b100; ew_light = 3'b100; btn_ew = 1'b1;
    tick(6); chk("held_req_ew", req_ew, 1);
    ew_light = 3'b001;
    tick(1); chk("held_grant_walk_ew", walk_ew, 1); chk("held_grant_req_ew", req_ew, 0);
    tick(13);
    chk("held_once_req_ew", req_ew, 0); chk("held_done_walk_ew", walk_ew, 0); chk("held_done_dw_ew", dw_ew, 1);
    btn_ew = 1'b0; ew_light = 3'b100;
    tick(3);
    btn_ew = 1'b1;
    tick(5); chk("second_early_req_ew", req_ew, 0);
    tick(1); chk("second_req_ew", req_ew, 1);
    btn_ew = 1'b0;
    ew_light = 3'b001;
    tick(1); chk("second_walk_ew", walk_ew, 1); chk("second_grant_req_ew", req_ew, 0);

    // Press during service, then abort at flash expiry
    btn_ew = 1'b1;
    tick(6);
    chk("mid_req_ew", req_ew, 1); chk("mid_cd_ew", cd_ew, 1); chk("mid_abort_ew", abort_ew, 0);
    btn_ew = 1'b0; ew_light = 3'b100;
    tick(1);
    chk("prio_abort_ew", abort_ew, 1); chk("prio_walk_ew", walk_ew, 0);
    chk("prio_cd_ew", cd_ew, 0);       chk("prio_dw_ew", dw_ew, 1);
    chk("prio_req_ew", req_ew, 1);

    // Conflicting lights raise fault and abort EW walk
    btn_ns = 1'b1;
    tick(6); btn_ns = 1'b0; chk("fault_setup_req_ns", req_ns, 1);
    ew_light = 3'b001;
    tick(1); chk("fault_setup_walk_ew", walk_ew, 1); chk("fault_setup_req_ew", req_ew, 0);
    ns_light = 3'b010; ew_light = 3'b001;
    tick(1);
    chk("fault_set", fault, 1); chk("fault_lag_walk_ew", walk_ew, 1);
    chk("fault_lag_abort_ew", abort_ew, 0); chk("fault_lag_req_ns", req_ns, 1);
    tick(1);
    chk("fault_walk_ew", walk_ew, 0); chk("fault_abort_ew", abort_ew, 1);
    chk("fault_dw_ew", dw_ew, 1);     chk("fault_req_ns", req_ns, 0);
    ns_light = 3'b001; ew_light = 3'b100; btn_ns = 1'b1;
    tick(8); btn_ns = 1'b0;
    chk("fault_sticky", fault, 1); chk("fault_ignore_req_ns", req_ns, 0);
    chk("fault_walk_ns", walk_ns, 0); chk("fault_dw_ns", dw_ns, 1);
    chk("fault_abort_ew_clear", abort_ew, 0);

    // Reset clears fault; then reset asynchronously mid-flash
    reset = 1'b1; #1;
    chk("rst_clear_fault", fault, 0);
    reset = 1'b0;
    ns_light = 3'b100; ew_light = 3'b001; btn_ns = 1'b1;
    tick(6); btn_ns = 1'b0; chk("r2_req_ns", req_ns, 1);
    ns_light = 3'b001; ew_light = 3'b100;
    tick(5); chk("r2_flash_cd_ns", cd_ns, 3); chk("r2_flash_dw_ns", dw_ns, 1);
    tick(1); chk("r2_flash2_cd_ns", cd_ns, 2); chk("r2_flash2_dw_ns", dw_ns, 0);
    #2 reset = 1'b1; #1;
    chk("mid_rst_walk_ns", walk_ns, 0); chk("mid_rst_dw_ns", dw_ns, 1);
    chk("mid_rst_cd_ns", cd_ns, 0);     chk("mid_rst_req_ns", req_ns, 0);
    chk("mid_rst_abort_ns", abort_ns, 0); chk("mid_rst_fault", fault, 0);
    reset = 1'b0;
    btn_ns = 1'b1;
    tick(6); btn_ns = 1'b0;
    chk("resume_req_ns", req_ns, 1); chk("resume_pre_walk_ns", walk_ns, 0);
    tick(1); chk("resume_walk_ns", walk_ns, 1); chk("resume_req_clr_ns", req_ns, 0);

    // Non-one-hot code
    ns_light = 3'b011;
    tick(1);
    chk("onehot_fault", fault, 1); chk("onehot_abort_ns", abort_ns, 1); chk("onehot_walk_ns", walk_ns, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
